// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared UART definitions used by the receiver, and also usable by uart_tx.
//   - Frame geometry (data bits per frame).
//   - Default bit period in clk cycles (100 MHz / 115200 baud).
//   - Receiver state encoding.
//   - 2-of-3 majority helper used when UART_RX_MAJORITY_EN is defined.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } uart_state_e;

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// -----------------------------------------------------------------------------
// uart_sync_2ff
//   Two-flop synchroniser for a single asynchronous level signal. Both flops
//   reset to 1 so an idle-high serial line is not seen as a start bit while
//   coming out of reset.
// Ports
//   clk  in  destination clock, rising edge
//   rst  in  asynchronous, active-high reset
//   i_d  in  asynchronous input
//   o_q  out synchronised copy of i_d (2 clk cycles of latency)
// -----------------------------------------------------------------------------
module uart_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, line
//   idle high. Each good byte is delivered with a one-cycle rx_valid pulse; a
//   low stop bit produces a one-cycle rx_frame_err pulse instead and leaves
//   rx_data untouched.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit, must be >= 4
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset (aborts any frame)
//   rx            in   serial input, asynchronous to clk, idle high
//   rx_data       out  [7:0] last correctly framed byte, held until next one
//   rx_valid      out  one-cycle pulse, rx_data has just been updated
//   rx_frame_err  out  one-cycle pulse, stop bit sampled low
//   rx_busy       out  high in every state except IDLE
//
// Configuration macro
//   UART_RX_MAJORITY_EN  when defined, each bit decision is a 2-of-3 vote of
//                        the synchronised line at counts mid-1, mid, mid+1,
//                        taken at mid+1 (outputs move one cycle later).
//                        When undefined, a single sample is taken at mid.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    // -------------------------------------------------------------------------
    // Input synchroniser
    // -------------------------------------------------------------------------
    logic w_rxs;

    uart_sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rxs)
    );

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    uart_state_e                r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [BIT_W-1:0]           r_bit_cnt;
    logic [UART_DATA_BITS-1:0]  r_shift;
    logic [UART_DATA_BITS-1:0]  r_data;
    logic                       r_valid;
    logic                       r_frame_err;

    uart_state_e                w_state_next;
    logic [CNT_W-1:0]           w_cnt_next;
    logic [BIT_W-1:0]           w_bit_cnt_next;
    logic [UART_DATA_BITS-1:0]  w_shift_next;
    logic [UART_DATA_BITS-1:0]  w_data_next;
    logic                       w_valid_next;
    logic                       w_frame_err_next;

    // -------------------------------------------------------------------------
    // Bit sampling
    //   The bit counter is cleared while idle and then runs freely, wrapping
    //   every CLKS_PER_BIT cycles, so count 0 is aligned with the start edge
    //   and CNT_MID falls in the middle of every bit of the frame.
    // -------------------------------------------------------------------------
    logic w_sample_tick;
    logic w_sample_bit;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] CNT_MID_P1 = CNT_W'(CLKS_PER_BIT / 2);

    logic r_vote_a;
    logic r_vote_b;

    // Capture the first two votes; the third is the live line at mid+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vote_a <= 1'b1;
            r_vote_b <= 1'b1;
        end else begin
            if (r_cnt == CNT_MID_M1) begin
                r_vote_a <= w_rxs;
            end
            if (r_cnt == CNT_MID) begin
                r_vote_b <= w_rxs;
            end
        end
    end

    assign w_sample_tick = (r_cnt == CNT_MID_P1);
    assign w_sample_bit  = maj3(r_vote_a, r_vote_b, w_rxs);
`else
    assign w_sample_tick = (r_cnt == CNT_MID);
    assign w_sample_bit  = w_rxs;
`endif

    // -------------------------------------------------------------------------
    // FSM: registered state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        w_bit_cnt_next   = r_bit_cnt;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_valid_next     = 1'b0;
        w_frame_err_next = 1'b0;

        case (r_state)
            IDLE: begin
                // Hold the counter at 0 so the first START cycle is count 0.
                w_cnt_next = '0;
                if (!w_rxs) begin
                    w_state_next = START;
                end
            end

            START: begin
                if (w_sample_tick) begin
                    if (!w_sample_bit) begin
                        w_state_next   = DATA;
                        w_bit_cnt_next = '0;
                    end else begin
                        // Line went back high before mid-bit: a glitch.
                        w_state_next = IDLE;
                    end
                end
            end

            DATA: begin
                if (w_sample_tick) begin
                    // LSB arrives first, so shift right and insert at the MSB.
                    w_shift_next = {w_sample_bit, r_shift[UART_DATA_BITS-1:1]};
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end

            STOP: begin
                // Leaving at mid-stop gives half a bit of slack to catch a
                // start bit that follows immediately.
                if (w_sample_tick) begin
                    if (w_sample_bit) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = WAIT_HI;
                    end
                end
            end

            WAIT_HI: begin
                // A break or stuck-low line must not be taken as a new start.
                w_cnt_next = '0;
                if (w_rxs) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed self-checking bench for uart_rx with CLKS_PER_BIT = 16. A task
//   plays the role of uart_tx, driving 8N1 frames bit by bit onto rx.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

`ifdef UART_RX_MAJORITY_EN
    localparam int          GLITCH_BUSY_LIMIT = 9;
    localparam logic [7:0]  MAJ_EXPECT        = 8'h78;
`else
    localparam int          GLITCH_BUSY_LIMIT = 8;
    localparam logic [7:0]  MAJ_EXPECT        = 8'h7C;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;

    // Monitor: every rx_valid pulse captures a byte, every error pulse counts.
    byte unsigned got_q[$];
    int           err_pulses = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
        end
        if (rx_frame_err) begin
            err_pulses++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame. glitch_b2 inverts rx for one cycle in the middle of
    // data bit 2; abort_bit stops driving at the middle of that frame bit
    // (0 = start, 1..8 = data, 9 = stop; >9 never aborts).
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input bit glitch_b2, input int abort_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b == abort_bit && c == CPB / 2) begin
                    return;
                end
                rx = bits[b] ^ (glitch_b2 && b == 3 && c == CPB / 2);
                tick(1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        rst = 1'b0;
        tick(3);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", rx_busy); end
        $display("test_reset: done, errors so far %0d", errors);
    endtask

    task automatic test_single();
        int e0;
        got_q.delete();
        e0 = err_pulses;
        send_frame(8'h78, 1'b1, 1'b0, 99);
        rx = 1'b1;
        tick(4);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d pulses expected 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] != 8'h78) begin errors++; $display("FAIL single_byte: got %h expected 78", got_q[0]); end
        end
        checks++; if (rx_data !== 8'h78) begin errors++; $display("FAIL single_data: got %h expected 78", rx_data); end
        checks++; if (err_pulses != e0) begin errors++; $display("FAIL single_err: got %0d error pulses expected 0", err_pulses - e0); end
        $display("test_single: sent 78, received %0d byte(s)", got_q.size());
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int e0;
        exp_b = '{8'h00, 8'hFF, 8'h55};
        got_q.delete();
        e0 = err_pulses;
        for (int i = 0; i < 3; i++) begin
            send_frame(exp_b[i], 1'b1, 1'b0, 99);
        end
        rx = 1'b1;
        tick(4);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d pulses expected 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (got_q.size() > i) begin
                checks++;
                if (got_q[i] != exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[i], exp_b[i]); end
            end
        end
        checks++; if (err_pulses != e0) begin errors++; $display("FAIL b2b_err: got %0d error pulses expected 0", err_pulses - e0); end
        $display("test_back_to_back: sent 00 FF 55, received %0d byte(s)", got_q.size());
    endtask

    task automatic test_glitch();
        int n;
        got_q.delete();
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b expected 1", rx_busy); end
        n = 0;
        while (rx_busy === 1'b1 && n < GLITCH_BUSY_LIMIT) begin
            tick(1);
            n++;
        end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: busy=%b after %0d cycles expected 0", rx_busy, n); end
        tick(20);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_valid: got %0d pulses expected 0", got_q.size()); end
        $display("test_glitch: busy dropped after %0d cycles", n);
    endtask

    task automatic test_framing();
        int e0;
        got_q.delete();
        e0 = err_pulses;
        send_frame(8'hA5, 1'b0, 1'b0, 99);
        tick(20);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL frame_busy_low: got %b expected 1", rx_busy); end
        checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL frame_err_count: got %0d expected 1", err_pulses - e0); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL frame_valid: got %0d pulses expected 0", got_q.size()); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL frame_data_held: got %h expected 55", rx_data); end
        rx = 1'b1;
        tick(4);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_release: got %b expected 0", rx_busy); end
        send_frame(8'h3C, 1'b1, 1'b0, 99);
        rx = 1'b1;
        tick(4);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL frame_next_count: got %0d pulses expected 1", got_q.size()); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL frame_next_data: got %h expected 3C", rx_data); end
        $display("test_framing: A5 with low stop, then 3C -> rx_data %h", rx_data);
    endtask

    task automatic test_reset_mid_frame();
        got_q.delete();
        send_frame(8'hC3, 1'b1, 1'b0, 5);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b expected 0", rx_frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", rx_busy); end
        tick(2);
        rx = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        send_frame(8'hC3, 1'b1, 1'b0, 99);
        rx = 1'b1;
        tick(4);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d pulses expected 1", got_q.size()); end
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL midrst_next_data: got %h expected C3", rx_data); end
        $display("test_reset_mid_frame: after reset, rx_data %h", rx_data);
    endtask

    task automatic test_majority();
        got_q.delete();
        send_frame(8'h78, 1'b1, 1'b1, 99);
        rx = 1'b1;
        tick(4);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL maj_count: got %0d pulses expected 1", got_q.size()); end
        checks++; if (rx_data !== MAJ_EXPECT) begin errors++; $display("FAIL maj_data: got %h expected %h", rx_data, MAJ_EXPECT); end
        $display("test_majority: glitched 78 -> rx_data %h", rx_data);
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
        test_majority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
